// File: rtl/solver_pkg.sv
// Shared types for the multi_solver result buffers and their reader.
// Pure declarations: no latency, no backpressure.
// Widths here are the defaults; the modules can override them.
package solver_pkg;

    localparam int DEF_ID_WIDTH   = 6;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE
    } readout_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/readout_fifo.sv
// Two-entry synchronous FIFO of beats; head is the oldest entry.
// Push lands on the next edge; head is visible the cycle after the push.
// No internal backpressure: the caller never pushes when full or pops when empty.
module readout_fifo import solver_pkg::*; #(
    parameter type T = beat_t
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  T           push_dat,
    input  logic       pop,
    output T           head,
    output logic [1:0] count
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/solver_readout.sv
// Drains full solver buffers round-robin into a valid/ready pixel stream, then releases them.
// Two cycles from the first read to the first out_valid; one beat per cycle thereafter.
// out_ready low holds the head beat; reads stop once two words are buffered or in flight.
// SOLVER_READOUT_CHECKSUM_EN adds out_checksum, the running XOR of the buffer's beats.
module solver_readout import solver_pkg::*; #(
    parameter int NUM_SOLVERS = 2,
    parameter int ID_WIDTH    = DEF_ID_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOLVERS-1:0] solver_done,
    output logic [NUM_SOLVERS-1:0] solver_release,
    output logic [ID_WIDTH-1:0]    rd_solver_id,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
`ifdef SOLVER_READOUT_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]  out_checksum,
`endif
    output logic [ID_WIDTH-1:0]    out_id,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_last
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  last;
    } rbeat_t;

    readout_state_t         state;
    logic [ID_WIDTH-1:0]    rr;
    logic                   inflight;
    logic [ID_WIDTH-1:0]    inf_id;
    logic [ADDR_WIDTH-1:0]  inf_addr;
    logic [1:0]             fifo_count;
    rbeat_t                 head;
    rbeat_t                 push_beat;
    logic                   pop;
    logic                   issue;
    logic [2:0]             credit_used;
    logic [ID_WIDTH-1:0]    grant_id;
    logic                   grant_found;
    logic [ID_WIDTH-1:0]    idx;
    logic [NUM_SOLVERS-1:0] rel_mask;

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // The beat popped this cycle frees its slot in time, which keeps a sustained stream bubble-free.
    assign credit_used = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue       = (state == READ) && (credit_used < 3'd2);

    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            idx = (int'(rr) + k >= NUM_SOLVERS) ? ID_WIDTH'(int'(rr) + k - NUM_SOLVERS)
                                                : ID_WIDTH'(int'(rr) + k);
            if (!grant_found && ((solver_done >> idx) & NUM_SOLVERS'(1)) != '0) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        rel_mask = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            rel_mask[k] = (rd_solver_id == ID_WIDTH'(k));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            rr             <= '0;
            rd_solver_id   <= '0;
            rd_addr        <= '0;
            solver_release <= '0;
            inflight       <= 1'b0;
            inf_id         <= '0;
            inf_addr       <= '0;
        end else begin
            inflight       <= issue;
            inf_id         <= rd_solver_id;
            inf_addr       <= rd_addr;
            solver_release <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state        <= READ;
                        rd_solver_id <= grant_id;
                        rd_addr      <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + 1'b1;
                        if (rd_addr == '1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && fifo_count == 2'd0) begin
                        state          <= RELEASE;
                        solver_release <= rel_mask;
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    rd_addr <= '0;
                    rr      <= (rd_solver_id == ID_WIDTH'(NUM_SOLVERS - 1)) ? '0 : rd_solver_id + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = rd_data;
        push_beat.id   = inf_id;
        push_beat.addr = inf_addr;
        push_beat.last = (inf_addr == '1);
    end

    readout_fifo #(.T(rbeat_t)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (inflight),
        .push_dat (push_beat),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    assign out_data = head.data;
    assign out_id   = head.id;
    assign out_addr = head.addr;
    assign out_last = head.last;

`ifdef SOLVER_READOUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_acc;

    always_ff @(posedge clock) begin
        if (reset || (state == IDLE && grant_found)) begin
            csum_acc <= '0;
        end else if (pop) begin
            csum_acc <= csum_acc ^ head.data;
        end
    end

    assign out_checksum = csum_acc ^ head.data;
`endif

endmodule
